// File: rtl/poly_pkg.sv
// Shared encodings for the polynomial evaluator: FSM states and ALU ops.
package poly_pkg;

  typedef enum logic [1:0] {
    LOAD      = 2'd0,
    LOAD_WAIT = 2'd1,
    MUL       = 2'd2,
    ADD       = 2'd3
  } state_t;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_MUL = 1'b1
  } alu_op_t;

endpackage

// File: rtl/poly_alu.sv
// Combinational unsigned multiply/add with truncated result and overflow flag.
module poly_alu
  import poly_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y,
  output logic             ovf
);

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_sum;

  // Full-precision product/sum; anything above WIDTH bits is overflow.
  always_comb begin
    w_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    w_sum  = {1'b0, a} + {1'b0, b};
    if (op == OP_MUL) begin
      y   = w_prod[WIDTH-1:0];
      ovf = |w_prod[2*WIDTH-1:WIDTH];
    end else begin
      y   = w_sum[WIDTH-1:0];
      ovf = w_sum[WIDTH];
    end
  end

endmodule

// File: rtl/poly_eval.sv
// Horner-rule polynomial evaluator: operands loaded one press at a time
// (a_N .. a_0, then x), then alternating MUL/ADD steps on one shared ALU.
module poly_eval
  import poly_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             overflow
);

  localparam int LW = $clog2(DEGREE + 2);
  localparam int IW = $clog2(DEGREE + 1);
  localparam logic [LW-1:0] X_SLOT   = LW'(DEGREE + 1);
  localparam logic [LW-1:0] TOP_SLOT = LW'(DEGREE);
  localparam logic [IW-1:0] I_TOP    = IW'(DEGREE);
  localparam logic [IW-1:0] I_START  = IW'(DEGREE - 1);

  state_t                      r_state, w_next;
  logic [LW-1:0]               r_load_idx;
  logic [IW-1:0]               r_i, w_widx;
  // Coefficients stored by power: r_coef[k] holds a_k.
  logic [DEGREE:0][WIDTH-1:0]  r_coef;
  logic [WIDTH-1:0]            r_acc, r_x, r_result, w_b, w_y;
  logic                        r_ovf_acc, r_overflow, w_ovf;
  alu_op_t                     w_op;

  assign result   = r_result;
  assign overflow = r_overflow;
  // Load slot k carries a_(N-k), so map the slot to its power.
  assign w_widx   = IW'(TOP_SLOT - r_load_idx);

  poly_alu #(.WIDTH(WIDTH)) u_alu (
    .a   (r_acc),
    .b   (w_b),
    .op  (w_op),
    .y   (w_y),
    .ovf (w_ovf)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= LOAD;
    else       r_state <= w_next;
  end

  // Next state, ALU steering and status outputs.
  always_comb begin
    w_next = r_state;
    w_op   = OP_MUL;
    w_b    = r_x;
    done   = 1'b0;
    busy   = 1'b0;
    case (r_state)
      LOAD:      if (go) w_next = LOAD_WAIT;
      LOAD_WAIT: if (!go) w_next = (r_load_idx == X_SLOT) ? MUL : LOAD;
      MUL: begin
        busy   = 1'b1;
        w_next = ADD;
      end
      ADD: begin
        busy = 1'b1;
        w_op = OP_ADD;
        w_b  = r_coef[r_i];
        if (r_i == '0) begin
          done   = 1'b1;
          w_next = LOAD;
        end else begin
          w_next = MUL;
        end
      end
      default: w_next = LOAD;
    endcase
  end

  // Operand capture, accumulator steps and result/overflow update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_idx <= '0;
      r_i        <= '0;
      r_coef     <= '0;
      r_acc      <= '0;
      r_x        <= '0;
      r_ovf_acc  <= 1'b0;
      r_result   <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (go) begin
            if (r_load_idx == X_SLOT) r_x <= data_in;
            else                      r_coef[w_widx] <= data_in;
          end
        end
        LOAD_WAIT: begin
          if (!go) begin
            if (r_load_idx == X_SLOT) begin
              r_acc     <= r_coef[I_TOP];
              r_i       <= I_START;
              r_ovf_acc <= 1'b0;
            end else begin
              r_load_idx <= r_load_idx + 1'b1;
            end
          end
        end
        MUL: begin
          r_acc     <= w_y;
          r_ovf_acc <= r_ovf_acc | w_ovf;
        end
        ADD: begin
          r_acc     <= w_y;
          r_ovf_acc <= r_ovf_acc | w_ovf;
          if (r_i == '0) begin
            r_result   <= w_y;
            r_overflow <= r_ovf_acc | w_ovf;
            r_load_idx <= '0;
          end else begin
            r_i <= r_i - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval.sv
// Scoreboard bench: two evaluators (8-bit quadratic, 16-bit cubic) driven by
// press sequences; a reference Horner model fills per-instance queues and
// negedge monitors pop them on every done pulse.
module tb_poly_eval;

  localparam int DA = 2;
  localparam int DB = 3;

  typedef struct {
    longint res;
    bit     ovf;
    int     rel;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        go_a, go_b;
  logic [7:0]  din_a, res_a;
  logic [15:0] din_b, res_b;
  logic        done_a, busy_a, ovf_a, done_b, busy_b, ovf_b;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  exp_t   qa[$], qb[$];
  exp_t   ea, eb;
  bit     chk_a = 0, chk_b = 0;
  int     bcnt_a = 0, bcnt_b = 0;
  longint last_res[2];

  poly_eval #(.WIDTH(8), .DEGREE(DA)) dut_a (
    .clk(clk), .reset(reset), .go(go_a), .data_in(din_a),
    .result(res_a), .done(done_a), .busy(busy_a), .overflow(ovf_a));

  poly_eval #(.WIDTH(16), .DEGREE(DB)) dut_b (
    .clk(clk), .reset(reset), .go(go_b), .data_in(din_b),
    .result(res_b), .done(done_b), .busy(busy_b), .overflow(ovf_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Evaluate P(x) by Horner's rule with unbounded integers, flagging any
  // intermediate product or sum that does not fit in w bits.
  function automatic longint model(input int w, input longint co[$],
                                   input longint x, output bit ovf);
    longint m, acc;
    m   = 1;
    m   = m << w;
    acc = co[0];
    ovf = 0;
    for (int k = 1; k < co.size(); k++) begin
      acc = acc * x;
      if (acc >= m) ovf = 1;
      acc = acc % m;
      acc = acc + co[k];
      if (acc >= m) ovf = 1;
      acc = acc % m;
    end
    return acc;
  endfunction

  // Monitor A: result/overflow are checked the cycle after done.
  always @(negedge clk) begin
    if (reset) begin
      bcnt_a = 0;
      chk_a  = 0;
    end else begin
      if (chk_a) begin
        chk("a_result", res_a, ea.res);
        chk("a_overflow", ovf_a, ea.ovf);
        chk_a = 0;
      end
      if (busy_a) bcnt_a++;
      if (done_a) begin
        if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
        else begin
          ea = qa.pop_front();
          chk("a_latency", cyc - ea.rel, 2 * DA);
          chk("a_busy_cycles", bcnt_a, 2 * DA);
          chk_a = 1;
        end
        bcnt_a = 0;
      end
    end
  end

  // Monitor B.
  always @(negedge clk) begin
    if (reset) begin
      bcnt_b = 0;
      chk_b  = 0;
    end else begin
      if (chk_b) begin
        chk("b_result", res_b, eb.res);
        chk("b_overflow", ovf_b, eb.ovf);
        chk_b = 0;
      end
      if (busy_b) bcnt_b++;
      if (done_b) begin
        if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
        else begin
          eb = qb.pop_front();
          chk("b_latency", cyc - eb.rel, 2 * DB);
          chk("b_busy_cycles", bcnt_b, 2 * DB);
          chk_b = 1;
        end
        bcnt_b = 0;
      end
    end
  end

  task automatic set_go(input int u, input logic v);
    if (u == 0) go_a = v; else go_b = v;
  endtask

  task automatic set_din(input int u, input longint v);
    if (u == 0) din_a = 8'(v); else din_b = 16'(v);
  endtask

  // One press: go high for 'hold' cycles (data_in scrambled after the
  // first cycle), then low. Returns right after the release negedge.
  task automatic press(input int u, input longint v, input int hold);
    @(negedge clk);
    set_go(u, 1'b1);
    set_din(u, v);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      set_din(u, $urandom);
    end
    @(negedge clk);
    set_go(u, 1'b0);
    set_din(u, $urandom);
  endtask

  task automatic eval(input int u, input longint co[$], input longint x,
                      input int hold, input bit toggle);
    int     deg;
    exp_t   e;
    bit     o;
    longint cur;
    bit     pend;
    deg   = (u == 0) ? DA : DB;
    e.res = model((u == 0) ? 8 : 16, co, x, o);
    e.ovf = o;
    foreach (co[k]) press(u, co[k], hold);
    cur = (u == 0) ? longint'(res_a) : longint'(res_b);
    chk((u == 0) ? "a_result_hold" : "b_result_hold", cur, last_res[u]);
    press(u, x, hold);
    e.rel = cyc;
    if (u == 0) qa.push_back(e); else qb.push_back(e);
    if (toggle) begin
      for (int k = 1; k < 2 * deg; k++) begin
        @(negedge clk);
        set_go(u, 1'($urandom_range(0, 1)));
        set_din(u, $urandom);
      end
      @(negedge clk);
      set_go(u, 1'b0);
    end
    pend = 1;
    for (int t = 0; t < 60 && pend; t++) begin
      @(posedge clk);
      pend = (u == 0) ? (qa.size() != 0 || chk_a) : (qb.size() != 0 || chk_b);
    end
    if (pend) begin
      chk((u == 0) ? "a_done_timeout" : "b_done_timeout", 1, 0);
      if (u == 0) qa.delete(); else qb.delete();
    end
    last_res[u] = e.res;
  endtask

  initial begin
    longint cq[$];
    reset = 1'b1;
    go_a = 0; go_b = 0; din_a = 0; din_b = 0;
    last_res[0] = 0;
    last_res[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_result", res_a, 0);
    chk("reset_overflow", ovf_a, 0);
    chk("reset_done", done_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_b_result", res_b, 0);
    reset = 1'b0;

    // Basic: 2x^2+3x+4 at x=5 -> 69.
    cq = '{2, 3, 4};
    eval(0, cq, 5, 1, 0);
    // Overflow in the first product, then a clean evaluation clears it.
    cq = '{16, 0, 0};
    eval(0, cq, 16, 1, 0);
    cq = '{1, 1, 1};
    eval(0, cq, 2, 1, 0);
    // Long presses with data_in changing: only first-sampled values count.
    cq = '{1, 0, 0};
    eval(0, cq, 3, 10, 0);
    // go toggling during MUL/ADD must not capture; next run uses fresh a_N.
    cq = '{7, 9, 200};
    eval(0, cq, 3, 1, 1);
    cq = '{1, 2, 3};
    eval(0, cq, 4, 2, 0);

    // Randomized evaluations.
    for (int n = 0; n < 25; n++) begin
      int mx;
      mx = ($urandom_range(0, 1) != 0) ? 255 : 7;
      cq.delete();
      for (int k = 0; k <= DA; k++) cq.push_back(longint'($urandom_range(0, mx)));
      eval(0, cq, longint'($urandom_range(0, mx)), $urandom_range(1, 3),
           1'($urandom_range(0, 1)));
    end

    // Reset during the second MUL: no done, result cleared.
    press(0, 5, 1);
    press(0, 6, 1);
    press(0, 7, 1);
    press(0, 9, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_res[0] = 0;
    repeat (8) @(negedge clk);
    chk("abort_result", res_a, 0);
    chk("abort_overflow", ovf_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    cq = '{3, 0, 1};
    eval(0, cq, 6, 1, 0);

    // Cubic 16-bit instance: 1,2,3,4 at x=10 -> 1234.
    cq = '{1, 2, 3, 4};
    eval(1, cq, 10, 1, 0);
    for (int n = 0; n < 10; n++) begin
      cq.delete();
      for (int k = 0; k <= DB; k++) cq.push_back(longint'($urandom_range(0, 65535)));
      eval(1, cq, longint'($urandom_range(0, 300)), $urandom_range(1, 2),
           1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/poly_eval.md
POLY_EVAL -- requirements
Module: poly_eval

Interface
REQ-001 Parameter WIDTH, default 8, datapath and result width in bits (>=2).
REQ-002 Parameter DEGREE, default 2, polynomial degree N (>=1); DEGREE+1 coefficients.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-005 go  input  1  level-sensitive load strobe; one press = high then low.
REQ-006 data_in  input  WIDTH  operand presented with go.
REQ-007 result  output  WIDTH  registered P(x) mod 2^WIDTH from the last completed evaluation.
REQ-008 done  output  1  one-cycle pulse; result updated this cycle.
REQ-009 busy  output  1  high while evaluation is in progress.
REQ-010 overflow  output  1  registered; set when the last evaluation overflowed, updated together with result.

Function
REQ-011 Load order SHALL be a_N, a_(N-1), ..., a_0, then x; DEGREE+2 presses per evaluation.
REQ-012 States SHALL be LOAD, LOAD_WAIT, MUL, ADD.
REQ-013 LOAD with go=1: data_in SHALL be captured into slot load_idx on that edge, and the FSM SHALL enter LOAD_WAIT.
REQ-014 LOAD_WAIT SHALL hold while go=1 and ignore data_in.
REQ-015 LOAD_WAIT with go=0: load_idx SHALL increment and the FSM SHALL return to LOAD; if x was the slot captured, the FSM SHALL instead enter MUL with acc<=a_N, step i<=N-1, ovf_acc<=0.
REQ-016 MUL SHALL perform acc<=acc*x, truncated to WIDTH, then enter ADD.
REQ-017 ADD SHALL perform acc<=acc+a_i, truncated to WIDTH.
REQ-018 In ADD with i>0, the block SHALL decrement i and return to MUL.
REQ-019 In ADD with i=0, the block SHALL write result<=acc+a_0 and overflow<=final ovf_acc, pulse done, and enter LOAD with load_idx=0.
REQ-020 ovf_acc SHALL set sticky if any full-precision product exceeds 2^WIDTH-1 or any sum carries out; operands are unsigned.
REQ-021 Latency: done SHALL be high exactly 2*DEGREE cycles after the edge leaving x's LOAD_WAIT.
REQ-022 busy SHALL be 1 in MUL and ADD and 0 otherwise.
REQ-023 go SHALL be ignored in MUL and ADD; a press already high when LOAD is re-entered SHALL count as a new a_N capture.
REQ-024 result and overflow SHALL hold between evaluations; loading new operands SHALL NOT alter them.
REQ-025 done SHALL never assert outside ADD with i=0.

Reset
REQ-026 On reset, state SHALL be LOAD, load_idx=0, i=0, and acc, all coefficients, x, result, overflow, done, and busy SHALL be 0.
REQ-027 Reset SHALL take priority over every transition, including mid-load and mid-MUL/ADD; a partial evaluation SHALL be discarded without a done pulse.

Structure
REQ-028 Shared package poly_pkg SHALL hold the state encoding (LOAD, LOAD_WAIT, MUL, ADD) and the ALU op encoding (OP_ADD, OP_MUL).
REQ-029 Sub-module poly_alu SHALL be combinational: inputs a, b, op; outputs WIDTH-bit truncated y and ovf; one instance shared by MUL and ADD.
REQ-030 Coefficient storage SHALL be a (DEGREE+1)xWIDTH register array indexed by load_idx and i; load_idx width SHALL be clog2(DEGREE+2).

Verification (WIDTH=8, DEGREE=2 unless stated)
REQ-031 Press 2,3,4,5 -> done 4 cycles after last release, result=0x45 (69), overflow=0, busy high 4 cycles.
REQ-032 Press 16,0,0,16 -> result=0x00, overflow=1; then press 1,1,1,2 -> result=7, overflow=0.
REQ-033 Hold go high 10 cycles on each press while changing data_in; press 1,0,0,3 -> result=9 (first-sampled values only).
REQ-034 Toggle go during MUL/ADD -> no extra capture; next evaluation uses a fresh a_N.
REQ-035 Assert reset during second MUL -> no done, result=0, state LOAD; a subsequent full load evaluates correctly.
REQ-036 DEGREE=3, WIDTH=16: press 1,2,3,4, x=10 -> result=1234, done 6 cycles after x release.
